key_state_tracker: RTL

KEY_STATE_TRACKER -- requirements
Module: key_state_tracker

---
 rtl/pong_pkg.sv | 30 +++
 rtl/key_repeat_ctr.sv | 102 ++++++++++
 rtl/key_state_tracker.sv | 85 ++++++++
 3 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Keyboard scan codes and colour-key FSM state shared by the
//               key tracking logic.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam logic [7:0] c_CODE_W       = 8'h1D;
    localparam logic [7:0] c_CODE_S       = 8'h1B;
    localparam logic [7:0] c_CODE_UP      = 8'h75;
    localparam logic [7:0] c_CODE_DOWN    = 8'h72;
    localparam logic [7:0] c_CODE_P1_PREV = 8'h05;
    localparam logic [7:0] c_CODE_P1_NEXT = 8'h06;
    localparam logic [7:0] c_CODE_P2_PREV = 8'h6C;
    localparam logic [7:0] c_CODE_P2_NEXT = 8'h69;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_HELD   = 2'd1,
        KS_REPEAT = 2'd2
    } key_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_repeat_ctr.sv
`default_nettype none
// ============================================================================
// Module      : key_repeat_ctr
// Description : Press/hold FSM for one colour key; emits a one-cycle pulse per
//               fresh press. With KEY_AUTOREPEAT_EN defined, also auto-repeats.
// Revision    : 1.0 - initial release
// ============================================================================
module key_repeat_ctr
    import pong_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic i_press,
    input  logic i_release,
    input  logic i_clear,
    output logic o_pulse
);

    key_state_t r_state;
    key_state_t w_state_nxt;
    logic       r_pulse;
    logic       w_pulse_nxt;

`ifdef KEY_AUTOREPEAT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_delay_done;
    logic             w_period_done;

    assign w_delay_done  = (r_cnt == CNT_W'(REPEAT_DELAY - 1));
    assign w_period_done = (r_cnt == CNT_W'(REPEAT_PERIOD - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= KS_IDLE;
            r_pulse <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pulse <= w_pulse_nxt;
`ifdef KEY_AUTOREPEAT_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    // The counter restarts from zero on every state entry and on each repeat pulse.
    always_comb begin
        w_state_nxt = r_state;
`ifdef KEY_AUTOREPEAT_EN
        w_cnt_nxt   = '0;
`endif
        if (i_clear) begin
            w_state_nxt = KS_IDLE;
        end else begin
            case (r_state)
                KS_IDLE: begin
                    if (i_press) w_state_nxt = KS_HELD;
                end
                KS_HELD: begin
                    if (i_release) w_state_nxt = KS_IDLE;
`ifdef KEY_AUTOREPEAT_EN
                    else if (w_delay_done) w_state_nxt = KS_REPEAT;
                    else w_cnt_nxt = r_cnt + 1'b1;
`endif
                end
                KS_REPEAT: begin
                    if (i_release) w_state_nxt = KS_IDLE;
`ifdef KEY_AUTOREPEAT_EN
                    else if (!w_period_done) w_cnt_nxt = r_cnt + 1'b1;
`endif
                end
                default: w_state_nxt = KS_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pulse_nxt = 1'b0;
        if (!i_clear) begin
            case (r_state)
                KS_IDLE:   w_pulse_nxt = i_press;
`ifdef KEY_AUTOREPEAT_EN
                KS_HELD:   w_pulse_nxt = !i_release && w_delay_done;
                KS_REPEAT: w_pulse_nxt = !i_release && w_period_done;
`endif
                default:   w_pulse_nxt = 1'b0;
            endcase
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/key_state_tracker.sv
`default_nettype none
// ============================================================================
// Module      : key_state_tracker
// Description : Tracks held paddle keys and generates colour-step pulses from
//               keyboard make/break events. Optional macro: KEY_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module key_state_tracker
    import pong_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       valid,
    input  logic       makeBreak,
    input  logic [7:0] outCode,
    input  logic       freeze,
    output logic       w_key,
    output logic       s_key,
    output logic       up_arrow_key,
    output logic       down_arrow_key,
    output logic       p1_prev,
    output logic       p1_next,
    output logic       p2_prev,
    output logic       p2_next
);

    localparam int          c_CNT_W        = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [31:0] c_COLOUR_CODES = {c_CODE_P2_NEXT, c_CODE_P2_PREV,
                                              c_CODE_P1_NEXT, c_CODE_P1_PREV};

    logic       w_event;
    logic [3:0] r_held;
    logic [3:0] w_pulse;

    // Events arriving while frozen are dropped, not deferred.
    assign w_event = valid & ~freeze;

    always_ff @(posedge CLOCK_50) begin
        if (reset || freeze) begin
            r_held <= 4'b0000;
        end else if (w_event) begin
            case (outCode)
                c_CODE_W:    r_held[3] <= makeBreak;
                c_CODE_S:    r_held[2] <= makeBreak;
                c_CODE_UP:   r_held[1] <= makeBreak;
                c_CODE_DOWN: r_held[0] <= makeBreak;
                default:     r_held    <= r_held;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_colour
            logic w_match;
            assign w_match = w_event && (outCode == c_COLOUR_CODES[gi*8 +: 8]);

            key_repeat_ctr #(
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD),
                .CNT_W         (c_CNT_W)
            ) u_ctr (
                .clk       (CLOCK_50),
                .rst       (reset),
                .i_press   (w_match & makeBreak),
                .i_release (w_match & ~makeBreak),
                .i_clear   (freeze),
                .o_pulse   (w_pulse[gi])
            );
        end
    endgenerate

    assign w_key          = r_held[3];
    assign s_key          = r_held[2];
    assign up_arrow_key   = r_held[1];
    assign down_arrow_key = r_held[0];
    assign p1_prev        = w_pulse[0];
    assign p1_next        = w_pulse[1];
    assign p2_prev        = w_pulse[2];
    assign p2_next        = w_pulse[3];

endmodule
`default_nettype wire
